// File: rtl/vtx_instr_tracker.sv
// rtl/vtx_instr_tracker.sv - passive per-instruction trace capture on the CPU<->COP interface
module vtx_instr_tracker #(
   parameter int TIMEOUT   = 64,
   parameter int MEM_SLOTS = 4
) (
   input  logic                      g_clk,
   input  logic                      g_resetn,
   input  logic                      cpu_insn_req,
   input  logic                      cop_insn_ack,
   input  logic                      cop_insn_rsp,
   input  logic                      cpu_insn_ack,
   input  logic [31:0]               insn_enc,
   input  logic [31:0]               insn_rs1,
   input  logic [2:0]                cop_result,
   input  logic [31:0]               cop_wdata,
   input  logic [4:0]                cop_waddr,
   input  logic                      cop_wen,
   input  logic [511:0]              cprs_in,
   input  logic                      mem_cen,
   input  logic                      mem_wen,
   input  logic                      mem_gnt,
   input  logic [31:0]               mem_addr,
   input  logic [31:0]               mem_wdata,
   input  logic [3:0]                mem_ben,
   input  logic                      mem_rsp,
   input  logic [31:0]               mem_rdata,
   input  logic                      mem_error,
   output logic                      vtx_reset,
   output logic                      vtx_valid,
   output logic [31:0]               vtx_instr_enc,
   output logic [31:0]               vtx_instr_rs1,
   output logic [2:0]                vtx_instr_result,
   output logic [31:0]               vtx_instr_wdata,
   output logic [4:0]                vtx_instr_waddr,
   output logic                      vtx_instr_wen,
   output logic [511:0]              vtx_cprs_pre,
   output logic [511:0]              vtx_cprs_post,
   output logic [MEM_SLOTS-1:0]      vtx_mem_cen,
   output logic [MEM_SLOTS-1:0]      vtx_mem_wen,
   output logic [32*MEM_SLOTS-1:0]   vtx_mem_addr,
   output logic [32*MEM_SLOTS-1:0]   vtx_mem_wdata,
   output logic [32*MEM_SLOTS-1:0]   vtx_mem_rdata,
   output logic [4*MEM_SLOTS-1:0]    vtx_mem_ben,
   output logic [MEM_SLOTS-1:0]      vtx_mem_error,
   output logic                      vtx_mem_ovf,
   output logic                      vtx_timeout
);

   localparam int CW = $clog2(MEM_SLOTS + 1);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t r_state, w_state_nxt;
   logic   w_issue, w_retire, w_cap_issue, w_active, w_done, w_tmo_hit;

   // in-flight instruction
   logic [31:0]             r_enc, r_rs1;
   logic [511:0]            r_pre;
   logic [TW-1:0]           r_tmo;
   logic [CW-1:0]           r_req_cnt, r_rsp_cnt, w_req_cnt, w_rsp_cnt;
   logic [MEM_SLOTS-1:0]    r_m_cen, r_m_wen, r_m_err, w_m_cen, w_m_wen, w_m_err;
   logic [32*MEM_SLOTS-1:0] r_m_addr, r_m_wdata, r_m_rdata, w_m_addr, w_m_wdata, w_m_rdata;
   logic [4*MEM_SLOTS-1:0]  r_m_ben, w_m_ben;
   logic                    r_m_ovf, w_m_ovf;
   int                      w_ri, w_qi;

   // report record
   logic [31:0]             r_rep_enc, r_rep_rs1, r_rep_wdata;
   logic [2:0]              r_rep_result;
   logic [4:0]              r_rep_waddr;
   logic                    r_rep_wen, r_rep_ovf;
   logic [511:0]            r_rep_pre, r_rep_post;
   logic [MEM_SLOTS-1:0]    r_rep_cen, r_rep_mwen, r_rep_err;
   logic [32*MEM_SLOTS-1:0] r_rep_addr, r_rep_mwdata, r_rep_rdata;
   logic [4*MEM_SLOTS-1:0]  r_rep_ben;
   logic                    r_done_d1, r_valid, r_timeout, r_rst_q1, r_rst_q2;

   assign w_issue     = cpu_insn_req & cop_insn_ack;
   assign w_retire    = cop_insn_rsp & cpu_insn_ack;
   assign w_cap_issue = (r_state == S_IDLE) & w_issue;
   assign w_active    = w_cap_issue | (r_state == S_BUSY);

   // next state; retire wins over a timeout landing in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_tmo_hit   = 1'b0;
      case (r_state)
         S_IDLE: if (w_issue) w_state_nxt = S_BUSY;
         S_BUSY: begin
            if (w_retire) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
               w_tmo_hit   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // memory slot update; the issue cycle starts from empty slots, responses pair with earlier requests
   always_comb begin
      w_req_cnt = w_cap_issue ? '0 : r_req_cnt;
      w_rsp_cnt = w_cap_issue ? '0 : r_rsp_cnt;
      w_m_cen   = w_cap_issue ? '0 : r_m_cen;
      w_m_wen   = w_cap_issue ? '0 : r_m_wen;
      w_m_err   = w_cap_issue ? '0 : r_m_err;
      w_m_addr  = w_cap_issue ? '0 : r_m_addr;
      w_m_wdata = w_cap_issue ? '0 : r_m_wdata;
      w_m_rdata = w_cap_issue ? '0 : r_m_rdata;
      w_m_ben   = w_cap_issue ? '0 : r_m_ben;
      w_m_ovf   = w_cap_issue ? 1'b0 : r_m_ovf;
      w_ri      = int'(w_rsp_cnt);
      w_qi      = int'(w_req_cnt);
      if (w_active) begin
         if (mem_rsp) begin
            if (w_rsp_cnt < w_req_cnt) begin
               w_m_rdata[32*w_ri +: 32] = mem_rdata;
               w_m_err[w_ri]            = mem_error;
               w_rsp_cnt                = w_rsp_cnt + CW'(1);
            end else begin
               w_m_ovf = 1'b1;
            end
         end
         if (mem_cen & mem_gnt) begin
            if (w_req_cnt < CW'(MEM_SLOTS)) begin
               w_m_cen[w_qi]            = 1'b1;
               w_m_wen[w_qi]            = mem_wen;
               w_m_addr[32*w_qi +: 32]  = mem_addr;
               w_m_wdata[32*w_qi +: 32] = mem_wdata;
               w_m_ben[4*w_qi +: 4]     = mem_ben;
               w_req_cnt                = w_req_cnt + CW'(1);
            end else begin
               w_m_ovf = 1'b1;
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge g_clk) begin
      if (!g_resetn) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // in-flight capture: issue snapshot, timeout counter, memory slots
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         r_enc     <= '0;
         r_rs1     <= '0;
         r_pre     <= '0;
         r_tmo     <= '0;
         r_req_cnt <= '0;
         r_rsp_cnt <= '0;
         r_m_cen   <= '0;
         r_m_wen   <= '0;
         r_m_err   <= '0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_m_rdata <= '0;
         r_m_ben   <= '0;
         r_m_ovf   <= 1'b0;
      end else begin
         if (w_cap_issue) begin
            r_enc <= insn_enc;
            r_rs1 <= insn_rs1;
            r_pre <= cprs_in;
            r_tmo <= '0;
         end else if (r_state == S_BUSY) begin
            r_tmo <= r_tmo + TW'(1);
         end
         r_req_cnt <= w_req_cnt;
         r_rsp_cnt <= w_rsp_cnt;
         r_m_cen   <= w_m_cen;
         r_m_wen   <= w_m_wen;
         r_m_err   <= w_m_err;
         r_m_addr  <= w_m_addr;
         r_m_wdata <= w_m_wdata;
         r_m_rdata <= w_m_rdata;
         r_m_ben   <= w_m_ben;
         r_m_ovf   <= w_m_ovf;
      end
   end

   // report copy at retire, including memory activity of the retire cycle itself
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         r_rep_enc    <= '0;
         r_rep_rs1    <= '0;
         r_rep_result <= '0;
         r_rep_wdata  <= '0;
         r_rep_waddr  <= '0;
         r_rep_wen    <= 1'b0;
         r_rep_pre    <= '0;
         r_rep_cen    <= '0;
         r_rep_mwen   <= '0;
         r_rep_err    <= '0;
         r_rep_addr   <= '0;
         r_rep_mwdata <= '0;
         r_rep_rdata  <= '0;
         r_rep_ben    <= '0;
         r_rep_ovf    <= 1'b0;
      end else if (w_done) begin
         r_rep_enc    <= r_enc;
         r_rep_rs1    <= r_rs1;
         r_rep_result <= cop_result;
         r_rep_wdata  <= cop_wdata;
         r_rep_waddr  <= cop_waddr;
         r_rep_wen    <= cop_wen;
         r_rep_pre    <= r_pre;
         r_rep_cen    <= w_m_cen;
         r_rep_mwen   <= w_m_wen;
         r_rep_err    <= w_m_err;
         r_rep_addr   <= w_m_addr;
         r_rep_mwdata <= w_m_wdata;
         r_rep_rdata  <= w_m_rdata;
         r_rep_ben    <= w_m_ben;
         r_rep_ovf    <= w_m_ovf;
      end
   end

   // post snapshot one cycle after retire so the writeback is visible, then the valid strobe
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         r_done_d1  <= 1'b0;
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
         r_rep_post <= '0;
      end else begin
         r_done_d1 <= w_done;
         r_valid   <= r_done_d1;
         r_timeout <= w_tmo_hit;
         if (r_done_d1) r_rep_post <= cprs_in;
      end
   end

   // reset indicator stretched one cycle past release
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         r_rst_q1 <= 1'b1;
         r_rst_q2 <= 1'b1;
      end else begin
         r_rst_q1 <= 1'b0;
         r_rst_q2 <= r_rst_q1;
      end
   end

   assign vtx_reset        = r_rst_q2;
   assign vtx_valid        = r_valid;
   assign vtx_timeout      = r_timeout;
   assign vtx_instr_enc    = r_rep_enc;
   assign vtx_instr_rs1    = r_rep_rs1;
   assign vtx_instr_result = r_rep_result;
   assign vtx_instr_wdata  = r_rep_wdata;
   assign vtx_instr_waddr  = r_rep_waddr;
   assign vtx_instr_wen    = r_rep_wen;
   assign vtx_cprs_pre     = r_rep_pre;
   assign vtx_cprs_post    = r_rep_post;
   assign vtx_mem_cen      = r_rep_cen;
   assign vtx_mem_wen      = r_rep_mwen;
   assign vtx_mem_addr     = r_rep_addr;
   assign vtx_mem_wdata    = r_rep_mwdata;
   assign vtx_mem_rdata    = r_rep_rdata;
   assign vtx_mem_ben      = r_rep_ben;
   assign vtx_mem_error    = r_rep_err;
   assign vtx_mem_ovf      = r_rep_ovf;

endmodule
